train_led_tx: RTL and testbench

TRAIN_LED_TX -- requirements
Module: train_led_tx

---
 rtl/train_led_pkg.sv | 26 ++
 rtl/train_led_bit_enc.sv | 64 ++++++
 rtl/train_led_tx.sv | 168 ++++++++++++++++
 tb/tb_train_led_tx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/train_led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : train_led_pkg
//  Description : Shared timing defaults and transmitter state encoding for
//                the TrainLED serial transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package train_led_pkg;

    // Default cell timing in clk cycles
    localparam int c_bit_clks   = 16;
    localparam int c_t0h        = 3;
    localparam int c_t1h        = 9;
    localparam int c_latch_clks = 128;

    // HIGH launches the first cell of a word, LOW covers cells in flight,
    // LATCH is the low gap that makes every node display its word.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/train_led_bit_enc.sv
`default_nettype none
// ============================================================================
//  Module      : train_led_bit_enc
//  Description : One TrainLED bit cell: dout high for T0H/T1H clocks, then
//                low for the rest of BIT_CLKS. A start on the final clock of
//                a cell begins the next cell with no gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module train_led_bit_enc #(
    parameter int BIT_CLKS = 16,
    parameter int T0H      = 3,
    parameter int T1H      = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_in,
    output logic dout,
    output logic cell_done
);

    localparam int                  c_cnt_w     = $clog2(BIT_CLKS);
    localparam logic [c_cnt_w-1:0]  c_cell_last = c_cnt_w'(BIT_CLKS - 1);
    localparam logic [c_cnt_w-1:0]  c_t0_last   = c_cnt_w'(T0H - 1);
    localparam logic [c_cnt_w-1:0]  c_t1_last   = c_cnt_w'(T1H - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_active;
    logic               r_bit;
    logic               r_dout;
    logic               w_high_last;

    assign w_high_last = r_bit ? (r_cnt == c_t1_last) : (r_cnt == c_t0_last);
    assign cell_done   = r_active && (r_cnt == c_cell_last);
    assign dout        = r_dout;

    // Cell counter and registered line driver; start wins over cell end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_bit    <= 1'b0;
            r_dout   <= 1'b0;
        end else if (start) begin
            r_cnt    <= '0;
            r_active <= 1'b1;
            r_bit    <= bit_in;
            r_dout   <= 1'b1;
        end else if (r_active) begin
            if (r_cnt == c_cell_last) begin
                r_cnt    <= '0;
                r_active <= 1'b0;
                r_dout   <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (w_high_last) begin
                    r_dout <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/train_led_tx.sv
`default_nettype none
// ============================================================================
//  Module      : train_led_tx
//  Description : TrainLED chain transmitter. 12-bit node words pass through a
//                one-entry holding register, are shifted out MSB first as
//                PWM bit cells, and a frame ends with a low latch gap.
//                Optional macro TRAIN_LED_TX_AUTOLATCH_EN: an underrun after
//                a non-last word ends the frame with a latch gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module train_led_tx
    import train_led_pkg::*;
#(
    parameter int BIT_CLKS   = c_bit_clks,
    parameter int T0H        = c_t0h,
    parameter int T1H        = c_t1h,
    parameter int LATCH_CLKS = c_latch_clks
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        dout,
    output logic        busy
);

    localparam int                 c_gap_w    = $clog2(LATCH_CLKS);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(LATCH_CLKS - 1);

`ifdef TRAIN_LED_TX_AUTOLATCH_EN
    localparam logic c_autolatch = 1'b1;
`else
    localparam logic c_autolatch = 1'b0;
`endif

    generate
        if (T0H < 1 || T0H > 4 || T1H < 8 || T1H > 11 ||
            BIT_CLKS < T1H + 2 || LATCH_CLKS < 104) begin : g_param_err
            $error("train_led_tx: timing parameters out of range");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [11:0]        r_shift;
    logic               r_last;
    logic [3:0]         r_bit_cnt;
    logic [c_gap_w-1:0] r_gap_cnt;
    logic [11:0]        r_hold_data;
    logic               r_hold_last;
    logic               r_hold_full;

    logic               w_accept;
    logic               w_load;
    logic               w_shift;
    logic               w_start;
    logic               w_bit;
    logic               w_cell_done;

    assign in_ready = !r_hold_full;
    assign busy     = (r_state != IDLE);
    assign w_accept = in_valid && !r_hold_full;

    // Sequencing: launch cells, chain words back to back, end frames
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_start     = 1'b0;
        w_bit       = r_shift[11];
        case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = HIGH;
                end
            end
            HIGH: begin
                w_start     = 1'b1;
                w_bit       = r_shift[11];
                w_state_nxt = LOW;
            end
            LOW: begin
                if (w_cell_done) begin
                    if (r_bit_cnt != 4'd11) begin
                        w_shift = 1'b1;
                        w_start = 1'b1;
                        w_bit   = r_shift[10];
                    end else if (r_last) begin
                        w_state_nxt = LATCH;
                    end else if (r_hold_full) begin
                        // Next word starts on the same edge: no idle clock
                        w_load  = 1'b1;
                        w_start = 1'b1;
                        w_bit   = r_hold_data[11];
                    end else if (c_autolatch) begin
                        w_state_nxt = LATCH;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            LATCH: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, shifter, bit/gap counters and holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_last      <= 1'b0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_hold_data <= '0;
            r_hold_last <= 1'b0;
            r_hold_full <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_load) begin
                r_shift   <= r_hold_data;
                r_last    <= r_hold_last;
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_shift   <= {r_shift[10:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end

            if (r_state == LATCH && w_state_nxt == LATCH) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end

            // A new word may land on the same edge the old one unloads
            if (w_accept) begin
                r_hold_data <= in_data;
                r_hold_last <= in_last;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    train_led_bit_enc #(
        .BIT_CLKS (BIT_CLKS),
        .T0H      (T0H),
        .T1H      (T1H)
    ) u_bit_enc (
        .clk       (clk),
        .rst       (rst),
        .start     (w_start),
        .bit_in    (w_bit),
        .dout      (dout),
        .cell_done (w_cell_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_train_led_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_train_led_tx
//  Description : Self-checking bench for train_led_tx: waveform-level model,
//                per-cycle compare, receiver-chain decoder and directed cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_train_led_tx;

    localparam int BIT_CLKS   = 16;
    localparam int T0H        = 3;
    localparam int T1H        = 9;
    localparam int LATCH_CLKS = 128;

`ifdef TRAIN_LED_TX_AUTOLATCH_EN
    localparam bit AUTOLATCH = 1'b1;
`else
    localparam bit AUTOLATCH = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [11:0] in_data  = '0;
    logic        in_valid = 1'b0;
    logic        in_last  = 1'b0;
    logic        in_ready;
    logic        dout;
    logic        busy;

    always #5 clk = ~clk;

    train_led_tx #(
        .BIT_CLKS   (BIT_CLKS),
        .T0H        (T0H),
        .T1H        (T1H),
        .LATCH_CLKS (LATCH_CLKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .dout     (dout),
        .busy     (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- waveform model: queue of future (dout,busy) samples
    typedef struct packed {
        logic d;
        logic b;
        logic eow;   // last sample of a non-last word
    } samp_t;

    samp_t       mq[$];
    logic        m_full    = 1'b0;
    logic        m_last    = 1'b0;
    logic        m_cont    = 1'b0;
    logic [11:0] m_data    = '0;
    logic        exp_dout  = 1'b0;
    logic        exp_busy  = 1'b0;
    logic        exp_ready = 1'b1;

    task automatic model_gap();
        for (int k = 0; k < LATCH_CLKS; k++) mq.push_back(samp_t'{1'b0, 1'b1, 1'b0});
    endtask

    task automatic model_word(input logic [11:0] w, input logic last, input logic lead);
        int th;
        if (lead) mq.push_back(samp_t'{1'b0, 1'b1, 1'b0});
        for (int i = 11; i >= 0; i--) begin
            th = w[i] ? T1H : T0H;
            for (int k = 0; k < BIT_CLKS; k++)
                mq.push_back(samp_t'{(k < th) ? 1'b1 : 1'b0, 1'b1,
                                     (!last && i == 0 && k == BIT_CLKS - 1) ? 1'b1 : 1'b0});
        end
        if (last) model_gap();
    endtask

    initial begin : p_model
        logic  acc;
        samp_t s;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_full   = 1'b0;
                m_cont   = 1'b0;
                exp_dout = 1'b0;
                exp_busy = 1'b0;
            end else begin
                acc = in_valid && !m_full;
                if (mq.size() == 0) begin
                    if (m_full) begin
                        model_word(m_data, m_last, !m_cont);
                        m_full = 1'b0;
                    end else if (m_cont && AUTOLATCH) begin
                        model_gap();
                    end
                end
                if (acc) begin
                    m_full = 1'b1;
                    m_data = in_data;
                    m_last = in_last;
                end
                if (mq.size() > 0) begin
                    s        = mq.pop_front();
                    exp_dout = s.d;
                    exp_busy = s.b;
                    m_cont   = s.eow;
                end else begin
                    exp_dout = 1'b0;
                    exp_busy = 1'b0;
                    m_cont   = 1'b0;
                end
            end
            exp_ready = !m_full;
        end
    end

    // Per-cycle compare against the model
    initial begin : p_compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc_dout",  dout,     exp_dout);
                check("cyc_busy",  busy,     exp_busy);
                check("cyc_ready", in_ready, exp_ready);
            end
        end
    end

    // ---------------- receiver chain: each node keeps its 12 bits in order
    int          cyc       = 0;
    int          hi        = 0;
    int          nbits     = 0;
    logic [11:0] cur       = '0;
    int          widths[$];
    int          rises[$];
    logic [11:0] words[$];
    int          busy_cnt  = 0;
    int          busy_fall = 0;
    logic        prev_busy = 1'b0;

    initial begin : p_decode
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                hi    = 0;
                nbits = 0;
            end else begin
                if (dout === 1'b1) begin
                    if (hi == 0) rises.push_back(cyc);
                    hi++;
                end else if (hi > 0) begin
                    widths.push_back(hi);
                    cur = {cur[10:0], (hi > (T0H + T1H) / 2) ? 1'b1 : 1'b0};
                    hi  = 0;
                    nbits++;
                    if (nbits == 12) begin
                        words.push_back(cur);
                        nbits = 0;
                    end
                end
                if (busy === 1'b1) busy_cnt++;
                if (prev_busy === 1'b1 && busy === 1'b0) busy_fall = cyc;
            end
            prev_busy = busy;
        end
    end

    // ---------------- stimulus helpers
    task automatic clear_obs();
        widths.delete();
        rises.delete();
        words.delete();
        busy_cnt = 0;
    endtask

    // Present a word (valid stays high) and return once it has been taken
    task automatic push(input logic [11:0] d, input logic l, output int waits);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        waits    = 0;
        while (in_ready !== 1'b1 && waits < 1000) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 1000) check("push_ready_timeout", in_ready, 1);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy === 1'b0 && in_ready === 1'b1) && n < 3000);
        if (n >= 3000) check("idle_timeout", n, 0);
        repeat (4) @(negedge clk);
    endtask

    int exp_w[12] = '{9, 3, 9, 3, 3, 9, 3, 9, 9, 9, 3, 3};

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        int w1, w2, w3, bad, n;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout",  dout,     0);
        check("rst_busy",  busy,     0);
        check("rst_ready", in_ready, 1);
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Single last word 0xA5C: widths, pitch, latch gap
        clear_obs();
        push(12'hA5C, 1'b1, w1);
        in_valid = 1'b0;
        wait_idle();
        check("a5c_cells", widths.size(), 12);
        if (widths.size() == 12 && rises.size() == 12) begin
            for (int i = 0; i < 12; i++) check($sformatf("a5c_width%0d", i), widths[i], exp_w[i]);
            bad = 0;
            for (int i = 1; i < 12; i++) if (rises[i] - rises[i-1] != BIT_CLKS) bad++;
            check("a5c_pitch", bad, 0);
            check("a5c_gap_end", busy_fall - rises[11], 144);
        end
        if (words.size() > 0) check("a5c_word", words[0], 12'hA5C);

        // Three back-to-back words, valid held high: chain of three nodes
        clear_obs();
        push(12'h123, 1'b0, w1);
        push(12'h456, 1'b0, w2);
        push(12'h789, 1'b1, w3);
        in_valid = 1'b0;
        wait_idle();
        check("b2b_w2_ready_wait", w2, 1);
        check("b2b_w3_ready_wait", w3, 192);
        check("b2b_cells", widths.size(), 36);
        if (rises.size() == 36) begin
            bad = 0;
            for (int i = 1; i < 36; i++) if (rises[i] - rises[i-1] != BIT_CLKS) bad++;
            check("b2b_pitch", bad, 0);
        end
        check("b2b_nodes", words.size(), 3);
        if (words.size() == 3) begin
            check("node0", words[0], 12'h123);
            check("node1", words[1], 12'h456);
            check("node2", words[2], 12'h789);
        end

        // Reset during the 5th cell, then a fresh word
        clear_obs();
        push(12'hFFF, 1'b1, w1);
        in_valid = 1'b0;
        n = 0;
        while (rises.size() < 5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("rst_wait_cell5", rises.size(), 5);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_dout",  dout,     0);
        check("midrst_busy",  busy,     0);
        check("midrst_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_obs();
        push(12'h9A3, 1'b1, w1);
        in_valid = 1'b0;
        wait_idle();
        check("postrst_words", words.size(), 1);
        if (words.size() > 0) check("postrst_word", words[0], 12'h9A3);

        // Underrun after a non-last word
        clear_obs();
        push(12'h3C3, 1'b0, w1);
        in_valid = 1'b0;
        wait_idle();
        if (words.size() > 0) check("underrun_word", words[0], 12'h3C3);
        check("underrun_busy_clks", busy_cnt, AUTOLATCH ? 321 : 193);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
